// File: rtl/ad_serial_responder.sv
// ad_serial_responder
//   Data-source end of the AD read handshake. On a request it runs one
//   SPI-style frame on a serial ADC (chip-select, serial clock, MSB-first
//   capture) and returns the sample with a one-cycle read_ready pulse.
//
//   Build option AD_PREFETCH_EN: frames run back to back without waiting for
//   read_req. Each completed sample lands in a one-entry buffer, and a request
//   is answered from that buffer. With the macro undefined, the block is
//   purely request-driven and has no buffer.
module ad_serial_responder #(
  parameter int DATA_W       = 16,
  parameter int CLK_DIV      = 4,
  parameter int NULL_BITS    = 0,
  parameter int QUIET_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_req,
  output logic              read_ready,
  output logic [DATA_W-1:0] read_data,
  output logic              ad_cs_n,
  output logic              ad_sclk,
  input  logic              ad_sdo,
  output logic              busy
);

  localparam int TOTAL_BITS = NULL_BITS + DATA_W;
  localparam int BIT_W      = $clog2(TOTAL_BITS + 1);

  localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]       QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(TOTAL_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              ready_nxt;
  logic              cs_n_nxt;
  logic              sclk_nxt;
  logic              frame_done;

`ifdef AD_PREFETCH_EN
  logic [DATA_W-1:0] buf_data, buf_data_nxt;
  logic              buf_valid, buf_valid_nxt;
`endif

  assign busy = (state != IDLE);

  // Next-state, counters, serial pins and handshake outputs. The serial
  // shift register is only DATA_W wide, so leading null bits simply fall
  // off its top end as the payload shifts in behind them.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    data_nxt   = read_data;
    ready_nxt  = 1'b0;
    cs_n_nxt   = ad_cs_n;
    sclk_nxt   = ad_sclk;
    frame_done = 1'b0;
`ifdef AD_PREFETCH_EN
    buf_data_nxt  = buf_data;
    buf_valid_nxt = buf_valid;
`endif

    case (state)
      IDLE: begin
`ifdef AD_PREFETCH_EN
        state_nxt = SETUP;
        cs_n_nxt  = 1'b0;
        div_nxt   = 8'd0;
`else
        if (read_req) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          div_nxt   = 8'd0;
        end
`endif
      end

      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = SHIFT;
          sclk_nxt  = 1'b1;
          div_nxt   = 8'd0;
          bit_nxt   = '0;
          shreg_nxt = {shreg[DATA_W-2:0], ad_sdo};
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = 8'd0;
          if (ad_sclk) begin
            sclk_nxt = 1'b0;
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt  = DONE;
            cs_n_nxt   = 1'b1;
            frame_done = 1'b1;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            sclk_nxt  = 1'b1;
            shreg_nxt = {shreg[DATA_W-2:0], ad_sdo};
          end
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end

      // DONE is the first cycle of the quiet interval; both share div_cnt.
      DONE, QUIET: begin
        if (div_cnt == QUIET_LAST) begin
          div_nxt = 8'd0;
`ifdef AD_PREFETCH_EN
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = QUIET;
          div_nxt   = div_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cs_n_nxt  = 1'b1;
        sclk_nxt  = 1'b0;
        div_nxt   = 8'd0;
        bit_nxt   = '0;
      end
    endcase

`ifdef AD_PREFETCH_EN
    // Consume first, then let a completing frame re-fill the buffer.
    if (read_req && buf_valid) begin
      ready_nxt     = 1'b1;
      data_nxt      = buf_data;
      buf_valid_nxt = 1'b0;
    end
    if (frame_done) begin
      buf_data_nxt  = shreg;
      buf_valid_nxt = 1'b1;
    end
`else
    // A request dropped mid-frame means the sample is discarded here.
    if (frame_done && read_req) begin
      ready_nxt = 1'b1;
      data_nxt  = shreg;
    end
`endif
  end

  // State and output registers; reset aborts any frame on the pins at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= '0;
      shreg      <= '0;
      read_data  <= '0;
      read_ready <= 1'b0;
      ad_cs_n    <= 1'b1;
      ad_sclk    <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      read_data  <= data_nxt;
      read_ready <= ready_nxt;
      ad_cs_n    <= cs_n_nxt;
      ad_sclk    <= sclk_nxt;
    end
  end

`ifdef AD_PREFETCH_EN
  // One-entry sample buffer for prefetch operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else begin
      buf_data  <= buf_data_nxt;
      buf_valid <= buf_valid_nxt;
    end
  end
`endif

endmodule
